// File: rtl/aes_pkg.sv
// aes_pkg: shared state encoding and block geometry for the AES stream controller.
package aes_pkg;
    localparam int AES_BLK_W  = 128;
    localparam int AES_WORD_W = 32;
    localparam int AES_WORDS  = 4;
    typedef enum logic [2:0] {IDLE, POP, LATCH, RUN, SEND} state_e;
endpackage

// File: rtl/aes_tx_serializer.sv
// aes_tx_serializer: loads a 128-bit block and streams it MSW first over valid/ready.
module aes_tx_serializer
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  load_i,
    input  logic [AES_BLK_W-1:0]  data_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [AES_WORD_W-1:0] data_o,
    output logic                  accept_o,
    output logic                  last_o
);
    logic [AES_BLK_W-1:0] blk_q;
    logic [1:0]           idx_q;
    logic                 valid_q;
    assign accept_o = valid_q && ready_i;
    assign last_o   = idx_q == 2'(AES_WORDS - 1);
    assign valid_o  = valid_q;
    assign data_o   = blk_q[AES_BLK_W-1 -: AES_WORD_W];
    // shifting the block keeps the current word at the top; it drains to zero after the last word
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            blk_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            blk_q   <= data_i;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (accept_o) begin
            blk_q   <= blk_q << AES_WORD_W;
            idx_q   <= idx_q + 2'd1;
            valid_q <= !last_o;
        end
    end
endmodule

// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: sequences RX FIFO pop, AES core start/wait and word-stream output per job.
module aes_stream_ctrl
    import aes_pkg::*;
#(
    parameter int ENC_LATENCY = 34,
    parameter int DEC_LATENCY = 40,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  enable_i,
    input  logic                  cfg_encrypt_i,
    input  logic [AES_BLK_W-1:0]  cfg_key_i,
    input  logic                  rx_fifo_full_i,
    input  logic [AES_BLK_W-1:0]  rx_data_i,
    output logic                  rx_read_en_o,
    output logic                  core_start_o,
    output logic                  core_encrypt_enable_o,
    output logic [AES_BLK_W-1:0]  core_data_in_o,
    output logic [AES_BLK_W-1:0]  core_key_o,
    input  logic [AES_BLK_W-1:0]  core_data_out_i,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic [AES_WORD_W-1:0] tx_data_o,
    output logic                  busy_o,
    output logic                  job_done_o,
    output logic [CNT_W-1:0]      job_count_o
);
    localparam int MAX_LAT = ENC_LATENCY > DEC_LATENCY ? ENC_LATENCY : DEC_LATENCY;
    localparam int LAT_W   = $clog2(MAX_LAT + 1);
    state_e               state_q, state_d;
    logic [LAT_W-1:0]     cnt_q, cnt_d;
    logic                 core_start_q, core_enc_q, job_done_q, job_done_d;
    logic [AES_BLK_W-1:0] core_data_q, core_key_q;
    logic [CNT_W-1:0]     job_count_q;
    logic                 ser_load, ser_accept, ser_last;
    assign ser_load              = state_q == RUN && cnt_q == '0;
    assign job_done_d            = state_q == SEND && ser_accept && ser_last;
    assign rx_read_en_o          = state_q == POP;
    assign busy_o                = state_q != IDLE;
    assign core_start_o          = core_start_q;
    assign core_encrypt_enable_o = core_enc_q;
    assign core_data_in_o        = core_data_q;
    assign core_key_o            = core_key_q;
    assign job_done_o            = job_done_q;
    assign job_count_o           = job_count_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:  state_d = (enable_i && rx_fifo_full_i) ? POP : IDLE;
            POP:   state_d = LATCH;
            LATCH: begin
                state_d = RUN;
                cnt_d   = cfg_encrypt_i ? LAT_W'(ENC_LATENCY - 1) : LAT_W'(DEC_LATENCY - 1);
            end
            RUN: begin
                state_d = (cnt_q == '0) ? SEND : RUN;
                cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - LAT_W'(1);
            end
            SEND:    state_d = (ser_accept && ser_last) ? IDLE : SEND;
            default: state_d = IDLE;
        endcase
    end
    // core inputs are only written when leaving LATCH, so they hold steady for the whole job
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            core_start_q <= 1'b0;
            core_enc_q   <= 1'b0;
            core_data_q  <= '0;
            core_key_q   <= '0;
            job_done_q   <= 1'b0;
            job_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_start_q <= state_q == LATCH;
            job_done_q   <= job_done_d;
            if (state_q == LATCH) begin
                core_enc_q  <= cfg_encrypt_i;
                core_data_q <= rx_data_i;
                core_key_q  <= cfg_key_i;
            end
            if (job_done_d) job_count_q <= job_count_q + CNT_W'(1);
        end
    end
    aes_tx_serializer u_ser (
        .clk      (clk),
        .n_rst    (n_rst),
        .load_i   (ser_load),
        .data_i   (core_data_out_i),
        .ready_i  (tx_ready_i),
        .valid_o  (tx_valid_o),
        .data_o   (tx_data_o),
        .accept_o (ser_accept),
        .last_o   (ser_last)
    );
endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: job-level vectors plus corner sequences, with a behavioural core stand-in.
module tb_aes_stream_ctrl;
    localparam logic [127:0] KEY = 128'h5E74E7BA66B0C7CC1B7697B3F9F51527;
    localparam logic [127:0] PT  = 128'h7D8AE0F7CFA0A6CB09FB5D05A8EC586D;
    localparam logic [127:0] CT  = 128'hdeb0f81341f3503a7cd01e2bc7cdd556;
    localparam int ENC_L = 34;
    localparam int DEC_L = 40;

    logic         clk = 1'b0, n_rst, enable, cfg_encrypt, rx_fifo_full, tx_ready;
    logic [127:0] cfg_key, rx_data, core_data_out;
    logic         rx_read_en, core_start, core_encrypt_enable, tx_valid, busy, job_done;
    logic [127:0] core_data_in, core_key;
    logic [31:0]  tx_data;
    logic [15:0]  job_count;

    typedef struct {
        logic         enc;
        logic [127:0] key;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;
    vec_t        tbl[6];
    logic [31:0] sb_q[$];
    int          n_cmp = 0, n_err = 0, jobs = 0, k = 1000;

    aes_stream_ctrl dut (
        .clk                   (clk),
        .n_rst                 (n_rst),
        .enable_i              (enable),
        .cfg_encrypt_i         (cfg_encrypt),
        .cfg_key_i             (cfg_key),
        .rx_fifo_full_i        (rx_fifo_full),
        .rx_data_i             (rx_data),
        .rx_read_en_o          (rx_read_en),
        .core_start_o          (core_start),
        .core_encrypt_enable_o (core_encrypt_enable),
        .core_data_in_o        (core_data_in),
        .core_key_o            (core_key),
        .core_data_out_i       (core_data_out),
        .tx_valid_o            (tx_valid),
        .tx_ready_i            (tx_ready),
        .tx_data_o             (tx_data),
        .busy_o                (busy),
        .job_done_o            (job_done),
        .job_count_o           (job_count)
    );

    always #5 clk = ~clk;

    // Known AES-128 vector pair; any other input gets a cheap mode- and key-dependent stand-in.
    function automatic logic [127:0] aes_ref(input logic [127:0] d, input logic [127:0] key, input logic e);
        if (key == KEY && e && d == PT) return CT;
        if (key == KEY && !e && d == CT) return PT;
        return e ? (d ^ key) : ({d[119:0], d[127:120]} ^ ~key);
    endfunction

    // Core stand-in: output is only correct from the cycle in which the controller must capture it.
    always @(negedge clk) begin
        if (core_start) k = 0;
        else if (k < 1000) k = k + 1;
        core_data_out = (k >= (core_encrypt_enable ? ENC_L : DEC_L) - 1)
                      ? aes_ref(core_data_in, core_key, core_encrypt_enable)
                      : ~aes_ref(core_data_in, core_key, core_encrypt_enable);
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic        stall_prev = 1'b0;
        logic [31:0] prev_data = '0;
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (tx_valid && tx_ready) begin
                    if (sb_q.size() == 0) check("extra_word", 128'(tx_data), 128'hx);
                    else check("tx_word", 128'(tx_data), 128'(sb_q.pop_front()));
                end
                if (stall_prev) begin
                    check("stall_valid", 128'(tx_valid), 128'(1));
                    check("stall_data", 128'(tx_data), 128'(prev_data));
                end
                if (job_done) check("done_vs_valid", 128'(tx_valid), 128'(0));
            end
            stall_prev = n_rst && tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    endtask

    task automatic start_job(input logic e, input logic [127:0] key, input logic [127:0] d, input logic [127:0] exp);
        @(posedge clk); #1;
        cfg_encrypt  = e;
        cfg_key      = key;
        rx_data      = d;
        rx_fifo_full = 1'b1;
        for (int i = 0; i < 4; i++) sb_q.push_back(exp[127-32*i -: 32]);
    endtask

    task automatic wait_pop();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rx_read_en) break;
        end
        check("pop_seen", 128'(rx_read_en), 128'(1));
        @(negedge clk);
        check("pop_one_cycle", 128'(rx_read_en), 128'(0));
        #1 rx_fifo_full = 1'b0;
    endtask

    task automatic wait_core_start();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (core_start) break;
        end
        check("core_start", 128'(core_start), 128'(1));
    endtask

    task automatic post_job();
        jobs++;
        check("job_count", 128'(job_count), 128'(16'(jobs)));
        check("sb_empty", 128'(sb_q.size()), 128'(0));
    endtask

    task automatic finish_job();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (job_done) break;
        end
        check("job_done", 128'(job_done), 128'(1));
        post_job();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_read_en"}, 128'(rx_read_en), 128'(0));
        check({tag, "_core_start"}, 128'(core_start), 128'(0));
        check({tag, "_core_enc"}, 128'(core_encrypt_enable), 128'(0));
        check({tag, "_core_data_in"}, core_data_in, 128'(0));
        check({tag, "_core_key"}, core_key, 128'(0));
        check({tag, "_tx_valid"}, 128'(tx_valid), 128'(0));
        check({tag, "_tx_data"}, 128'(tx_data), 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_job_done"}, 128'(job_done), 128'(0));
        check({tag, "_job_count"}, 128'(job_count), 128'(0));
    endtask

    initial begin
        n_rst = 1'b0; enable = 1'b1; cfg_encrypt = 1'b0; cfg_key = '0;
        rx_fifo_full = 1'b0; rx_data = '0; tx_ready = 1'b1;
        tbl[0] = '{1'b0, KEY, CT, PT};
        tbl[1] = '{1'b1, KEY, PT, CT};
        tbl[2] = '{1'b1, 128'h00112233445566778899aabbccddeeff, 128'h0f0e0d0c0b0a09080706050403020100, '0};
        tbl[3] = '{1'b0, 128'hffffffffffffffffffffffffffffffff, 128'h00000000000000000000000000000001, '0};
        tbl[4] = '{1'b1, 128'h0, 128'h80000000_00000000_00000000_00000000, '0};
        tbl[5] = '{1'b0, 128'hcafebabe_deadbeef_01234567_89abcdef, 128'h13579bdf_2468ace0_fedcba98_76543210, '0};
        for (int i = 2; i < 6; i++) tbl[i].exp = aes_ref(tbl[i].data, tbl[i].key, tbl[i].enc);
        fork monitor(); join_none
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 n_rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            start_job(tbl[i].enc, tbl[i].key, tbl[i].data, tbl[i].exp);
            wait_pop();
            finish_job();
        end

        // core_start cycle through first tx_valid cycle, both inclusive
        for (int m = 0; m < 2; m++) begin
            int cyc;
            logic e;
            e = m == 0;
            start_job(e, KEY, e ? PT : CT, e ? CT : PT);
            wait_pop();
            wait_core_start();
            check("busy_in_run", 128'(busy), 128'(1));
            @(negedge clk);
            check("start_pulse", 128'(core_start), 128'(0));
            cyc = 2;
            while (!tx_valid && cyc < 100) begin
                @(negedge clk);
                cyc++;
            end
            check(e ? "enc_latency" : "dec_latency", 128'(cyc), 128'(e ? ENC_L + 1 : DEC_L + 1));
            finish_job();
        end

        begin
            bit done = 1'b0;
            tx_ready = 1'b0;
            start_job(1'b1, tbl[2].key, tbl[2].data, tbl[2].exp);
            wait_pop();
            for (int i = 0; i < 100 && !tx_valid; i++) @(negedge clk);
            check("bp_valid", 128'(tx_valid), 128'(1));
            repeat (10) @(negedge clk);
            for (int i = 0; i < 200 && !done; i++) begin
                @(posedge clk); #1 tx_ready = ~tx_ready;
                @(negedge clk);
                if (job_done) done = 1'b1;
            end
            check("bp_done", 128'(done), 128'(1));
            tx_ready = 1'b1;
            post_job();
        end

        start_job(1'b1, KEY, PT, CT);
        wait_pop();
        wait_core_start();
        repeat (3) @(negedge clk);
        #1 cfg_encrypt = 1'b0; cfg_key = '0; rx_data = '0;
        repeat (2) @(negedge clk);
        check("snap_key", core_key, KEY);
        check("snap_enc", 128'(core_encrypt_enable), 128'(1));
        check("snap_data", core_data_in, PT);
        finish_job();

        begin
            bit seen = 1'b0;
            enable = 1'b0;
            start_job(1'b0, KEY, CT, PT);
            repeat (50) begin
                @(negedge clk);
                if (rx_read_en) seen = 1'b1;
            end
            check("no_pop_disabled", 128'(seen), 128'(0));
            @(posedge clk); #1 enable = 1'b1;
            @(negedge clk);
            check("en_cycle1", 128'(rx_read_en), 128'(0));
            @(negedge clk);
            check("en_cycle2", 128'(rx_read_en), 128'(1));
            @(posedge clk); #1 rx_fifo_full = 1'b0;
            finish_job();
        end

        start_job(1'b0, KEY, CT, PT);
        wait_pop();
        wait_core_start();
        repeat (DEC_L - 11) @(negedge clk);
        #1 n_rst = 1'b0;
        #1 check_all_zero("midrst");
        sb_q.delete();
        rx_fifo_full = 1'b0;
        jobs = 0;
        repeat (3) @(negedge clk);
        check_all_zero("midrst_hold");
        @(posedge clk); #1 n_rst = 1'b1;
        start_job(1'b1, KEY, PT, CT);
        wait_pop();
        finish_job();

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
